// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the unified memory port arbiter.
// Groups the fetch (I-side), load/store (D-side) and memory-side signals.
//   master : the arbiter's view (drives readies, responses and mem requests)
//   slave  : the environment's view (requesters plus memory)
// Clock and reset are not part of the bundle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // fetch side
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  // load/store side
  logic              dm_req_valid;
  logic              dm_req_we;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [DATA_W-1:0] dm_req_wdata;
  logic [3:0]        dm_req_be;
  logic              dm_req_ready;
  logic              dm_rsp_valid;
  logic [DATA_W-1:0] dm_rsp_data;
  // memory side
  logic              mem_ready;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_ready, mem_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
  );

  modport slave (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_ready, mem_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter.
// Shares one fixed-latency memory port between instruction fetch and the
// load/store path. At most one request is granted per cycle; D-side wins
// unless fetch has been denied STARVE_LIMIT consecutive cycles. A tag
// pipeline of READ_LATENCY stages remembers who owns each in-flight read so
// the returning mem_rdata is steered to the right requester. A fetch flush
// drops every in-flight fetch response.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.master (fetch, load/store and memory signals)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int         LAST       = READ_LATENCY - 1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  logic              starve;
  logic              grant_d;
  logic              grant_i;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [3:0]        be_sel;
  logic              we_sel;

  // Tag pipeline: index 0 is the newest grant, LAST is the one whose data
  // is on mem_rdata this cycle. owner: 0 = fetch, 1 = load/store.
  logic [READ_LATENCY-1:0] tag_v;
  logic [READ_LATENCY-1:0] tag_owner;
  logic [READ_LATENCY-1:0] tag_we;

  // Arbitration: D-side priority unless fetch is starving.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    starve  = (starve_cnt == STARVE_MAX);
    grant_d = ~reset & bus.mem_ready & bus.dm_req_valid
              & ~(starve & bus.if_req_valid);
    grant_i = ~reset & bus.mem_ready & bus.if_req_valid & ~grant_d;
  end

  // Request mux; fetches are full-word reads.
  always_comb begin
    addr_sel  = bus.if_req_addr;
    wdata_sel = '0;
    be_sel    = 4'hF;
    we_sel    = 1'b0;
    if (grant_d) begin
      addr_sel  = bus.dm_req_addr;
      wdata_sel = bus.dm_req_wdata;
      be_sel    = bus.dm_req_be;
      we_sel    = bus.dm_req_we;
    end
  end

  assign bus.dm_req_ready  = grant_d;
  assign bus.if_req_ready  = grant_i;
  assign bus.mem_req_valid = grant_d | grant_i;
  assign bus.mem_req_we    = we_sel;
  assign bus.mem_req_addr  = addr_sel;
  assign bus.mem_req_wdata = wdata_sel;
  assign bus.mem_req_be    = be_sel;

  // Starvation counter counts every denied fetch cycle, including cycles
  // where memory is busy, so fetch wins as soon as memory frees up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_i || !bus.if_req_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Tag valid bits: a flush kills fetch entries as they shift; the grant
  // entering stage 0 on the flush edge is post-redirect and survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= grant_d | grant_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1] & ~(bus.if_flush & ~tag_owner[i-1]);
      end
    end
  end

  // Tag payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    tag_owner[0] <= grant_d;
    tag_we[0]    <= we_sel;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_owner[i] <= tag_owner[i-1];
      tag_we[i]    <= tag_we[i-1];
    end
  end

  // Response steering from the oldest stage.
  assign bus.if_rsp_valid = tag_v[LAST] & ~tag_owner[LAST] & ~bus.if_flush;
  assign bus.dm_rsp_valid = tag_v[LAST] & tag_owner[LAST];
  assign bus.if_rsp_data  = bus.mem_rdata;
  assign bus.dm_rsp_data  = tag_we[LAST] ? '0 : bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .STARVE_LIMIT(3))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .STARVE_LIMIT(3))
    u3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        dmv;
    logic        dmwe;
    logic [31:0] dma;
    logic [31:0] dmwd;
    logic [3:0]  dmbe;
    logic        mrdy;
    logic [31:0] rdata;
    logic        e_ifr;
    logic        e_dmr;
    logic        e_mv;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_ifrsp;
    logic [31:0] e_ifd;
    logic        e_dmrsp;
    logic [31:0] e_dmd;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle1();
    b1.if_req_valid = 0; b1.if_req_addr = 0; b1.if_flush = 0;
    b1.dm_req_valid = 0; b1.dm_req_we = 0; b1.dm_req_addr = 0;
    b1.dm_req_wdata = 0; b1.dm_req_be = 4'hF; b1.mem_ready = 1; b1.mem_rdata = 0;
  endtask

  task automatic idle3();
    b3.if_req_valid = 0; b3.if_req_addr = 0; b3.if_flush = 0;
    b3.dm_req_valid = 0; b3.dm_req_we = 0; b3.dm_req_addr = 0;
    b3.dm_req_wdata = 0; b3.dm_req_be = 4'hF; b3.mem_ready = 1; b3.mem_rdata = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //            ifv  ifa           dmv  we   dma           dmwd          be    rdy  rdata         ifr  dmr  mv   we   addr          be    wd            ifrsp ifd          dmrsp dmd
    vecs[0]  = '{1'b1, 32'h01000000, 1'b0, 1'b0, 32'h0,        32'h0,        4'hF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h01000000, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h01000004, 1'b0, 1'b0, 32'h0,        32'h0,        4'hF, 1'b1, 32'h00000013, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01000004, 4'hF, 32'h0,        1'b1, 32'h00000013, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'hF, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00500093, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h01000008, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h01000008, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h11111111};
    vecs[5]  = '{1'b1, 32'h01000008, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h22222222};
    vecs[6]  = '{1'b1, 32'h01000008, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01000008, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h33333333};
    vecs[7]  = '{1'b1, 32'h0100000C, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0,        1'b1, 32'h44444444, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0100000C, 1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, 1'b1, 32'h55555555, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h55555555};
    vecs[9]  = '{1'b1, 32'h0100000C, 1'b1, 1'b1, 32'h20000010, 32'hDEADBEEF, 4'h3, 1'b1, 32'h66666666, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20000010, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 32'h66666666};
    vecs[10] = '{1'b1, 32'h0100000C, 1'b0, 1'b0, 32'h0,        32'h0,        4'hF, 1'b1, 32'h77777777, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0100000C, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000000};
    vecs[11] = '{1'b1, 32'h01000010, 1'b1, 1'b0, 32'h20000020, 32'h0,        4'hF, 1'b1, 32'h88888888, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20000020, 4'hF, 32'h0,        1'b1, 32'h88888888, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h01000010, 1'b1, 1'b0, 32'h20000020, 32'h0,        4'hF, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h99999999};
    vecs[13] = '{1'b1, 32'h01000010, 1'b1, 1'b0, 32'h20000020, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h01000010, 1'b1, 1'b0, 32'h20000020, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h01000010, 1'b1, 1'b0, 32'h20000020, 32'h0,        4'hF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h01000010, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'hF, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 32'hAAAAAAAA, 1'b0, 32'h0};

    // Reset state: requests present but reset high
    reset = 1'b1;
    idle1();
    idle3();
    next_cycle();
    b1.if_req_valid = 1; b1.dm_req_valid = 1;
    #1;
    chk("rst_if_ready", b1.if_req_ready, 1'b0);
    chk("rst_dm_ready", b1.dm_req_ready, 1'b0);
    chk("rst_mem_valid", b1.mem_req_valid, 1'b0);
    chk("rst_if_rsp", b1.if_rsp_valid, 1'b0);
    chk("rst_dm_rsp", b1.dm_rsp_valid, 1'b0);
    idle1();
    reset = 1'b0;
    next_cycle();

    // Table-driven run on the READ_LATENCY=1 instance
    for (int k = 0; k < NVEC; k++) begin
      b1.if_req_valid = vecs[k].ifv;
      b1.if_req_addr  = vecs[k].ifa;
      b1.dm_req_valid = vecs[k].dmv;
      b1.dm_req_we    = vecs[k].dmwe;
      b1.dm_req_addr  = vecs[k].dma;
      b1.dm_req_wdata = vecs[k].dmwd;
      b1.dm_req_be    = vecs[k].dmbe;
      b1.mem_ready    = vecs[k].mrdy;
      b1.mem_rdata    = vecs[k].rdata;
      #1;
      chk($sformatf("v%0d_if_ready", k), b1.if_req_ready, vecs[k].e_ifr);
      chk($sformatf("v%0d_dm_ready", k), b1.dm_req_ready, vecs[k].e_dmr);
      chk($sformatf("v%0d_mem_valid", k), b1.mem_req_valid, vecs[k].e_mv);
      if (vecs[k].e_mv) begin
        chk($sformatf("v%0d_mem_we", k), b1.mem_req_we, vecs[k].e_we);
        chk($sformatf("v%0d_mem_addr", k), b1.mem_req_addr, vecs[k].e_addr);
        chk($sformatf("v%0d_mem_be", k), b1.mem_req_be, vecs[k].e_be);
        chk($sformatf("v%0d_mem_wdata", k), b1.mem_req_wdata, vecs[k].e_wd);
      end
      chk($sformatf("v%0d_if_rsp", k), b1.if_rsp_valid, vecs[k].e_ifrsp);
      if (vecs[k].e_ifrsp) chk($sformatf("v%0d_if_data", k), b1.if_rsp_data, vecs[k].e_ifd);
      chk($sformatf("v%0d_dm_rsp", k), b1.dm_rsp_valid, vecs[k].e_dmrsp);
      if (vecs[k].e_dmrsp) chk($sformatf("v%0d_dm_data", k), b1.dm_rsp_data, vecs[k].e_dmd);
      next_cycle();
    end
    idle1();

    // READ_LATENCY=3: flush drops the old fetch, keeps the load and the new fetch
    b3.if_req_valid = 1; b3.if_req_addr = 32'h100;
    #1 chk("l3_c0_if_ready", b3.if_req_ready, 1'b1);
    next_cycle();
    b3.if_req_valid = 0; b3.dm_req_valid = 1; b3.dm_req_addr = 32'h300;
    #1 chk("l3_c1_dm_ready", b3.dm_req_ready, 1'b1);
    next_cycle();
    b3.dm_req_valid = 0; b3.if_req_valid = 1; b3.if_req_addr = 32'h200; b3.if_flush = 1;
    #1;
    chk("l3_c2_if_ready", b3.if_req_ready, 1'b1);
    chk("l3_c2_if_rsp", b3.if_rsp_valid, 1'b0);
    next_cycle();
    b3.if_req_valid = 0; b3.if_flush = 0; b3.mem_rdata = 32'hCAFE0001;
    #1;
    chk("l3_c3_if_rsp_dropped", b3.if_rsp_valid, 1'b0);
    chk("l3_c3_dm_rsp", b3.dm_rsp_valid, 1'b0);
    next_cycle();
    b3.mem_rdata = 32'hCAFE0002;
    #1;
    chk("l3_c4_dm_rsp", b3.dm_rsp_valid, 1'b1);
    chk("l3_c4_dm_data", b3.dm_rsp_data, 32'hCAFE0002);
    chk("l3_c4_if_rsp", b3.if_rsp_valid, 1'b0);
    next_cycle();
    b3.mem_rdata = 32'hCAFE0003;
    #1;
    chk("l3_c5_if_rsp", b3.if_rsp_valid, 1'b1);
    chk("l3_c5_if_data", b3.if_rsp_data, 32'hCAFE0003);
    chk("l3_c5_dm_rsp", b3.dm_rsp_valid, 1'b0);
    next_cycle();
    b3.mem_rdata = 32'h0;
    #1 chk("l3_c6_if_rsp", b3.if_rsp_valid, 1'b0);
    next_cycle();

    // Flush in the response cycle masks if_rsp_valid
    b3.if_req_valid = 1; b3.if_req_addr = 32'h400;
    #1 chk("l3_f0_if_ready", b3.if_req_ready, 1'b1);
    next_cycle();
    b3.if_req_valid = 0;
    next_cycle();
    next_cycle();
    b3.if_flush = 1;
    #1 chk("l3_f3_if_rsp_masked", b3.if_rsp_valid, 1'b0);
    next_cycle();
    b3.if_flush = 0;
    next_cycle();

    // Reset with two responses in flight
    b3.if_req_valid = 1; b3.if_req_addr = 32'h500;
    next_cycle();
    b3.if_req_valid = 0; b3.dm_req_valid = 1; b3.dm_req_addr = 32'h600;
    next_cycle();
    b3.dm_req_valid = 0;
    next_cycle();
    b3.mem_rdata = 32'h12345678;
    #1 chk("rr_if_rsp_before", b3.if_rsp_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rr_if_rsp_async", b3.if_rsp_valid, 1'b0);
    chk("rr_dm_rsp_async", b3.dm_rsp_valid, 1'b0);
    next_cycle();
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      #1;
      chk($sformatf("rr_post%0d_if_rsp", k), b3.if_rsp_valid, 1'b0);
      chk($sformatf("rr_post%0d_dm_rsp", k), b3.dm_rsp_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
